// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch front end.
//
// Generates fetch PCs, issues 16-bit word requests to instruction memory,
// buffers returned words with their PCs and presents them to decode with a
// valid/ready handshake. A taken-branch redirect flushes the buffer and
// discards responses still in flight. Fetch stops once an HLT (opcode 4'hF)
// has been received, and halts for good when decode consumes it.
//
// Parameters
//   RESET_PC        first PC fetched after reset
//   FIFO_DEPTH      buffer entries and in-flight request limit (power of 2, >= 2)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   imem_req/addr   request valid / word address (current fetch PC)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response valid (in request order, latency >= 1)
//   imem_rdata      returned instruction word
//   instr_valid     buffer head valid toward decode
//   instr           head instruction word
//   instr_pc        PC of head instruction
//   instr_pc_plus2  instr_pc + 2 (wraps)
//   instr_ready     decode consumes the head this cycle
//   redirect        branch taken: flush and refetch from redirect_pc
//   redirect_pc     new fetch PC
//   halted          sticky, set once decode has consumed an HLT
//
// Build option FETCH_PERF_EN adds perf_fetched (buffer pushes) and
// perf_stall (cycles with instr_valid && !instr_ready), both saturating.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [15:0] instr_pc_plus2,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_stall
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [15:0]   fetch_pc;

    logic [15:0]   buf_instr [FIFO_DEPTH];
    logic [15:0]   buf_pc    [FIFO_DEPTH];
    logic [PW-1:0] buf_wr;
    logic [PW-1:0] buf_rd;
    logic [CW-1:0] count;

    // PCs of outstanding requests; popped by every response, dropped or not,
    // so it always lines up with what memory returns next.
    logic [15:0]   pcq [FIFO_DEPTH];
    logic [PW-1:0] pcq_wr;
    logic [PW-1:0] pcq_rd;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop_cnt;

    logic          halt_seen;

    logic          redirect_eff;
    logic [CW-1:0] occupancy;
    logic          issue;
    logic          resp_drop;
    logic          push;
    logic          pop;

    always_comb begin
        redirect_eff = redirect && !halted;
        occupancy    = count + inflight;
        imem_req     = !rst && !halt_seen && !halted && !redirect && (occupancy < DEPTH_C);
        issue        = imem_req && imem_ready;
        resp_drop    = imem_rvalid && (drop_cnt != '0);
        // A response arriving with the redirect belongs to the old path too.
        push         = imem_rvalid && !resp_drop && !halt_seen && !redirect_eff;
        instr_valid  = !rst && (count != '0);
        pop          = instr_valid && instr_ready;
    end

    assign imem_addr      = fetch_pc;
    assign instr          = buf_instr[buf_rd];
    assign instr_pc       = buf_pc[buf_rd];
    assign instr_pc_plus2 = buf_pc[buf_rd] + 16'd2;

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[buf_wr] <= imem_rdata;
            buf_pc[buf_wr]    <= pcq[pcq_rd];
        end
        if (issue) begin
            pcq[pcq_wr] <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            buf_wr    <= '0;
            buf_rd    <= '0;
            count     <= '0;
            pcq_wr    <= '0;
            pcq_rd    <= '0;
            inflight  <= '0;
            drop_cnt  <= '0;
            halt_seen <= 1'b0;
            halted    <= 1'b0;
        end else begin
            if (issue) begin
                pcq_wr <= pcq_wr + 1'b1;
            end
            if (imem_rvalid) begin
                pcq_rd <= pcq_rd + 1'b1;
            end
            unique case ({issue, imem_rvalid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase

            if (pop && (instr[15:12] == 4'hF)) begin
                halted <= 1'b1;
            end

            if (redirect_eff) begin
                fetch_pc  <= redirect_pc;
                buf_rd    <= buf_wr;
                count     <= '0;
                halt_seen <= 1'b0;
                // Recomputed from scratch so a second redirect does not double count.
                drop_cnt  <= inflight - {{(CW-1){1'b0}}, imem_rvalid};
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 16'd2;
                end
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (push) begin
                    buf_wr <= buf_wr + 1'b1;
                    if (imem_rdata[15:12] == 4'hF) begin
                        halt_seen <= 1'b1;
                    end
                end
                if (pop) begin
                    buf_rd <= buf_rd + 1'b1;
                end
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && (perf_fetched != 16'hFFFF)) begin
                perf_fetched <= perf_fetched + 16'd1;
            end
            if (instr_valid && !instr_ready && (perf_stall != 16'hFFFF)) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

    // Every response and every buffered word was once a counted request.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst) occupancy <= DEPTH_C);
    a_resp_expected : assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (inflight != '0));

endmodule
